// File: rtl/matrix_dm_host_port_pkg.sv
// Shared types and defaults for the matrix processor DM host port.
package matrix_dm_host_port_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Level of proc_hold that keeps the processor in reset.
  localparam logic PROC_HOLD_RST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_UNLOAD_RD,
    ST_UNLOAD_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/matrix_dm_host_port.sv
// Host front end for the matrix processor data memory: streams operands
// into DM, releases the processor, waits for end_process, then streams the
// result region back out. All DM port outputs are decoded from the state.
module matrix_dm_host_port
  import matrix_dm_host_port_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TIMEOUT_W = 24
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] unload_base,
  input  logic [ADDR_W-1:0] unload_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              dm_en,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              proc_en,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              end_process,
  output logic              proc_hold,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  // A zero-width watchdog is disabled; keep a 1-bit dummy counter so the
  // declarations stay legal.
  localparam bit              WD_EN   = (TIMEOUT_W > 0);
  localparam int              WD_W    = WD_EN ? TIMEOUT_W : 1;
  localparam logic [WD_W-1:0] WD_ONES = '1;
  // Expiry is taken on the cycle whose increment makes the counter all-ones.
  localparam logic [WD_W-1:0] WD_LAST = WD_ONES - WD_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] load_len_q, unload_base_q, unload_len_q;
  logic [ADDR_W-1:0] cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              run_first;
  logic              out_first;
  logic [DATA_W-1:0] m_hold;
  logic              start_ok, load_beat, out_beat, wd_hit;

  // The first UNLOAD_OUT cycle presents the RAM output directly; afterwards
  // the captured copy keeps m_data stable while the sink stalls.
  assign m_data = out_first ? dm_rdata : m_hold;

  // Next-state decode and all combinational outputs, including the DM mux.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    dm_en     = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    proc_hold = PROC_HOLD_RST;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    load_beat = 1'b0;
    out_beat  = 1'b0;
    wd_hit    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (load_len == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) begin
          load_beat = 1'b1;
          dm_en     = 1'b1;
          dm_we     = 1'b1;
          dm_addr   = cnt;
          dm_wdata  = s_data;
          if (cnt == load_len_q - ADDR_W'(1)) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        proc_hold = ~PROC_HOLD_RST;
        dm_en     = proc_en;
        dm_we     = proc_we;
        dm_addr   = proc_addr;
        dm_wdata  = proc_wdata;
        // end_process may still be stale from a previous job on entry.
        if (end_process && !run_first) begin
          state_nxt = (unload_len_q == '0) ? ST_DONE : ST_UNLOAD_RD;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          wd_hit    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_UNLOAD_RD: begin
        busy      = 1'b1;
        dm_en     = 1'b1;
        dm_addr   = unload_base_q + cnt;
        state_nxt = ST_UNLOAD_OUT;
      end
      ST_UNLOAD_OUT: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready) begin
          out_beat  = 1'b1;
          state_nxt = (cnt == unload_len_q - ADDR_W'(1)) ? ST_DONE : ST_UNLOAD_RD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Job descriptor captured on an accepted start.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      load_len_q    <= '0;
      unload_base_q <= '0;
      unload_len_q  <= '0;
    end else if (start_ok) begin
      load_len_q    <= load_len;
      unload_base_q <= unload_base;
      unload_len_q  <= unload_len;
    end
  end

  // Shared byte counter: load count in LOAD, read count while unloading.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (start_ok)              cnt <= '0;
    else if (state == ST_RUN)       cnt <= '0;
    else if (load_beat || out_beat) cnt <= cnt + ADDR_W'(1);
  end

  // RUN watchdog counter, first-cycle marker and sticky timeout flag.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      run_first <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      wd_cnt    <= (state == ST_RUN) ? wd_cnt + WD_W'(1) : '0;
      run_first <= (state != ST_RUN) && (state_nxt == ST_RUN);
      if (start_ok)    timeout <= 1'b0;
      else if (wd_hit) timeout <= 1'b1;
    end
  end

  // Result byte capture on the cycle after each DM read.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_first <= 1'b0;
      m_hold    <= '0;
    end else begin
      out_first <= (state == ST_UNLOAD_RD);
      if (out_first) m_hold <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_matrix_dm_host_port.sv
// Randomized self-checking bench for matrix_dm_host_port with a DM model
// and a shadow memory describing what DM should hold.
module tb_matrix_dm_host_port;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] load_len = '0, unload_base = '0, unload_len = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic        dm_en, dm_we;
  logic [15:0] dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata = '0;
  logic        proc_en = 1'b0, proc_we = 1'b0;
  logic [15:0] proc_addr = '0;
  logic [7:0]  proc_wdata = '0;
  logic        end_process = 1'b0;
  logic        proc_hold, busy, done, timeout;

  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  int          wr_cnt = 0, rd_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  matrix_dm_host_port #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_W(4)) dut (
    .clock(clock), .rst(rst), .start(start), .load_len(load_len),
    .unload_base(unload_base), .unload_len(unload_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .proc_en(proc_en), .proc_we(proc_we),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .end_process(end_process),
    .proc_hold(proc_hold), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Synchronous-read DM with access counters.
  always @(posedge clock) begin
    if (dm_en) begin
      if (dm_we) begin
        mem[dm_addr] <= dm_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        dm_rdata <= mem[dm_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_hold", proc_hold, 1);
    check_val("rst_ctl", {s_ready, m_valid, dm_en, dm_we, busy, done, timeout}, 0);
    check_val("rst_addr", dm_addr, 0);
    check_val("rst_wdata", dm_wdata, 0);
    check_val("rst_mdata", m_data, 0);
  endtask

  // One complete job; ul must not exceed edly so the processor writes every result byte.
  task automatic run_job(input int ll, input int ub, input int ul, input int edly,
                         input bit cont, input int stall_k, input bit fixed);
    logic [7:0]  bytes[$];
    logic [7:0]  exp_q[$];
    logic [15:0] a;
    int wr0, rd0, i, k, j, cyc, stall_left;
    bytes = {};
    exp_q = {};
    for (int n = 0; n < ll; n++) bytes.push_back(fixed ? 8'(8'h11 * (n + 1)) : 8'($urandom));
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(posedge clock); #1;
    start = 1'b1;
    load_len = 16'(ll); unload_base = 16'(ub); unload_len = 16'(ul);
    s_valid = (ll > 0);
    s_data = (ll > 0) ? bytes[0] : 8'h00;
    @(negedge clock);
    check_val("start_no_wr", dm_en, 0);
    @(posedge clock); #1;
    start = 1'b0;
    load_len = 16'($urandom); unload_base = 16'($urandom); unload_len = 16'($urandom);
    check_val("tmo_clr", timeout, 0);
    i = 0; cyc = 0;
    while (i < ll && cyc < 200) begin
      s_valid = cont || ($urandom_range(0, 3) != 0);
      s_data = bytes[i];
      @(negedge clock);
      check_val("s_ready", s_ready, 1);
      check_val("hold_load", proc_hold, 1);
      if (s_valid) begin
        check_val("wr_en", {dm_en, dm_we}, 2'b11);
        check_val("wr_addr", dm_addr, i);
        check_val("wr_data", dm_wdata, bytes[i]);
        ref_mem[i] = bytes[i];
        i++;
      end else check_val("load_gap_en", dm_en, 0);
      @(posedge clock); #1;
      cyc++;
    end
    s_valid = 1'b0;
    check_val("load_beats", i, ll);
    check_val("wr_count", wr_cnt - wr0, ll);
    j = 0;
    while (j <= edly) begin
      proc_addr = 16'($urandom);
      proc_en = 1'b0; proc_we = 1'b0;
      if (j < ul) begin
        proc_en = 1'b1; proc_we = 1'b1;
        proc_addr = 16'(ub + j);
        proc_wdata = fixed ? 8'(8'hA0 + j) : 8'($urandom);
      end
      end_process = (j == edly) || (j == 0);
      @(negedge clock);
      check_val("hold_run", proc_hold, 0);
      check_val("s_ready_run", s_ready, 0);
      check_val("mux_ctl", {dm_en, dm_we}, {proc_en, proc_we});
      check_val("mux_addr", dm_addr, proc_addr);
      check_val("mux_wdata", dm_wdata, proc_wdata);
      if (proc_en && proc_we) ref_mem[proc_addr] = proc_wdata;
      @(posedge clock); #1;
      j++;
    end
    end_process = 1'b0; proc_en = 1'b0; proc_we = 1'b0;
    for (int n = 0; n < ul; n++) begin
      a = 16'(ub + n);
      exp_q.push_back(ref_mem[a]);
    end
    k = 0; cyc = 0; stall_left = 5;
    while (k < ul && cyc < 400) begin
      if (k == stall_k && stall_left > 0) m_ready = 1'b0;
      else m_ready = cont ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clock);
      check_val("hold_unload", proc_hold, 1);
      if (m_valid) begin
        check_val("m_data", m_data, exp_q[k]);
        if (m_ready) k++;
        else if (k == stall_k && stall_left > 0) stall_left--;
      end
      @(posedge clock); #1;
      cyc++;
    end
    m_ready = 1'b0;
    check_val("unload_beats", k, ul);
    @(negedge clock);
    check_val("done", done, 1);
    check_val("hold_done", proc_hold, 1);
    check_val("m_valid_end", m_valid, 0);
    check_val("busy_end", busy, 0);
    check_val("tmo_end", timeout, 0);
    check_val("rd_count", rd_cnt - rd0, ul);
    for (int n = 0; n < 8; n++) check_val("dm_load_content", mem[n], ref_mem[n]);
  endtask

  initial begin
    int run_cyc, wr0, ll, ul, ed;
    for (int n = 0; n < 65536; n++) ref_mem[n] = 8'h00;
    #3;
    check_reset_outputs();
    @(negedge clock);
    rst = 1'b1;

    // Directed: continuous load of 4 bytes, result A0..A2 at 0x0010 with a stall on byte 2.
    run_job(4, 16'h0010, 3, 10, 1'b1, 1, 1'b1);
    // Zero-length load and unload.
    run_job(0, 0, 0, 5, 1'b1, -1, 1'b0);

    // Watchdog expiry with end_process held low.
    @(posedge clock); #1;
    start = 1'b1; load_len = 16'd0; unload_base = 16'd0; unload_len = 16'd2;
    @(posedge clock); #1;
    start = 1'b0;
    run_cyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (proc_hold) break;
      run_cyc++;
      @(posedge clock); #1;
    end
    check_val("wd_run_cycles", run_cyc, 15);
    check_val("wd_timeout", timeout, 1);
    check_val("wd_done", done, 1);
    check_val("wd_hold", proc_hold, 1);

    // end_process on the expiry cycle wins; result addresses wrap past 0xFFFF.
    run_job(2, 16'hFFFE, 4, 14, 1'b0, -1, 1'b0);

    // Reset in the middle of a load.
    @(posedge clock); #1;
    start = 1'b1; load_len = 16'd4; unload_base = 16'h0020; unload_len = 16'd2;
    s_valid = 1'b1; s_data = 8'h5A;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    wr0 = wr_cnt;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_no_wr", wr_cnt - wr0, 0);
    s_valid = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    run_job(4, 16'h0020, 2, 6, 1'b1, -1, 1'b0);

    // Randomized jobs.
    for (int t = 0; t < 8; t++) begin
      ll = $urandom_range(0, 8);
      ul = $urandom_range(0, 6);
      ed = $urandom_range((ul > 0) ? ul : 1, 12);
      run_job(ll, $urandom_range(0, 65535), ul, ed, 1'b0, (t == 3) ? 0 : -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
